wb_ram_slave: RTL

- Wishbone B4 classic, pipelined-off, single-clock slave: a byte-lane-writable 32-bit RAM window that terminates the CPU's memory-request master.
- Accepts single read/write cycles, applies sel_i byte enables, and returns a single-cycle ack_o after a programmable number of wait states.
- Out-of-window addresses terminate with err_o instead of ack_o.
- Sits directly on the CPU's Wishbone master port; shares its clock and reset.

---
 rtl/wb_pkg.sv | 22 ++
 rtl/wb_bytemem.sv | 31 +++
 rtl/wb_ram_slave.sv | 117 +++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone B4 widths, slave FSM states and the captured request record.
// Every Wishbone slave in this slice imports these definitions.
package wb_pkg;

    localparam int WB_ADR_W = 30;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    typedef enum logic [1:0] {
        WB_IDLE,
        WB_WAIT,
        WB_TERM
    } wb_slv_state_t;

    typedef struct packed {
        logic                we;
        logic [WB_ADR_W-1:0] adr;
        logic [WB_SEL_W-1:0] sel;
        logic [WB_DAT_W-1:0] dat;
    } wb_req_t;

endpackage

// File: rtl/wb_bytemem.sv
// Single-port word array with byte-lane write enables and a registered read.
// The read port is free-running so that synthesis can map the array to block RAM.
module wb_bytemem
    import wb_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = 10
) (
    input  logic                clk,
    input  logic                we,
    input  logic [WB_SEL_W-1:0] be,
    input  logic [IDX_W-1:0]    idx,
    input  logic [WB_DAT_W-1:0] wdata,
    output logic [WB_DAT_W-1:0] rdata
);

    logic [WB_DAT_W-1:0] mem [DEPTH_WORDS];

    // Read-before-write: rdata shows the old word during a write edge.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int lane = 0; lane < WB_SEL_W; lane++) begin
                if (be[lane]) begin
                    mem[idx][8*lane +: 8] <= wdata[8*lane +: 8];
                end
            end
        end
        rdata <= mem[idx];
    end

endmodule

// File: rtl/wb_ram_slave.sv
// Wishbone B4 classic RAM slave with programmable wait states.
// Out-of-window accesses terminate with err_o; RAM contents survive reset.
module wb_ram_slave
    import wb_pkg::*;
#(
    parameter int                  DEPTH_WORDS = 1024,
    parameter logic [WB_ADR_W-1:0] BASE_WORD   = 30'h0000_3C00,
    parameter int                  WAIT_STATES = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cyc_i,
    input  logic                stb_i,
    input  logic                we_i,
    input  logic [WB_ADR_W-1:0] adr_i,
    input  logic [WB_SEL_W-1:0] sel_i,
    input  logic [WB_DAT_W-1:0] dat_i,
    output logic [WB_DAT_W-1:0] dat_o,
    output logic                ack_o,
    output logic                err_o
);

    localparam int         IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    wb_slv_state_t       state, next_state;
    logic [3:0]          wait_cnt;
    wb_req_t             req_q, req_live, cur_req;
    logic                ok_q, cur_ok, accept, mem_we;
    logic [WB_ADR_W-1:0] offset;
    logic [WB_DAT_W-1:0] rdata, dat_hold;

    // In IDLE the live bus fields drive the RAM so a zero-wait access can
    // commit or read on its accept edge; afterwards the captured copy is used.
    assign req_live = '{we: we_i, adr: adr_i, sel: sel_i, dat: dat_i};
    assign cur_req  = (state == WB_IDLE) ? req_live : req_q;
    assign offset   = cur_req.adr - BASE_WORD;
    assign cur_ok   = (offset < WB_ADR_W'(DEPTH_WORDS));
    assign accept   = (state == WB_IDLE) && cyc_i && stb_i;
    assign mem_we   = !rst_i && (next_state == WB_TERM) && (state != WB_TERM)
                      && cur_req.we && cur_ok;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= WB_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            WB_IDLE: begin
                if (accept) begin
                    next_state = (WAIT_STATES > 0) ? WB_WAIT : WB_TERM;
                end
            end
            WB_WAIT: begin
                if (!(cyc_i && stb_i)) begin
                    next_state = WB_IDLE;
                end else if (wait_cnt == 4'd0) begin
                    next_state = WB_TERM;
                end
            end
            WB_TERM: next_state = WB_IDLE;
            default: next_state = WB_IDLE;
        endcase
    end

    always_comb begin
        ack_o = 1'b0;
        err_o = 1'b0;
        dat_o = dat_hold;
        if (state == WB_TERM) begin
            ack_o = ok_q;
            err_o = !ok_q;
            if (ok_q && !req_q.we) begin
                dat_o = rdata;
            end
        end
    end

    // Request capture, wait countdown and the read-data hold register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_q    <= '0;
            ok_q     <= 1'b0;
            wait_cnt <= 4'd0;
            dat_hold <= '0;
        end else begin
            if (accept) begin
                req_q    <= req_live;
                ok_q     <= cur_ok;
                wait_cnt <= WAIT_LOAD;
            end else if (state == WB_WAIT && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (state == WB_TERM && ok_q && !req_q.we) begin
                dat_hold <= rdata;
            end
        end
    end

    wb_bytemem #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W)
    ) u_mem (
        .clk  (clk_i),
        .we   (mem_we),
        .be   (cur_req.sel),
        .idx  (offset[IDX_W-1:0]),
        .wdata(cur_req.dat),
        .rdata(rdata)
    );

endmodule
